// File: rtl/biu_prefetch_queue.sv
// Bus-interface prefetch unit for the 8088/8086: forms CS:FIP fetch addresses,
// runs a request/acknowledge fetch engine and holds fetched bytes in a circular queue.
module biu_prefetch_queue #(
  parameter int BUS_BYTES = 1,
  parameter int DEPTH     = 4,
  parameter int OUT_BYTES = 4
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [15:0]                    CS,
  input  logic                           IP_LOAD,
  input  logic [15:0]                    IP_NEW,
  input  logic                           EU_REQ,
  output logic                           MEM_REQ,
  output logic [19:0]                    MEM_ADDR,
  output logic [BUS_BYTES-1:0]           MEM_BE,
  input  logic                           MEM_ACK,
  input  logic [8*BUS_BYTES-1:0]         MEM_RDATA,
  input  logic [$clog2(OUT_BYTES+1)-1:0] POP,
  output logic [8*OUT_BYTES-1:0]         Q_OUT,
  output logic [$clog2(DEPTH+1)-1:0]     Q_COUNT,
  output logic [15:0]                    HEAD_IP,
  output logic                           UNDERRUN
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;
  state_t state;

  logic [7:0]           store [DEPTH];
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        wr_ptr;
  logic [15:0]          fip;

  logic [1:0]           fetch_size;
  logic [BUS_BYTES-1:0] be_next;
  logic [19:0]          addr_next;
  logic                 room_ok;
  logic                 write_en;
  logic [1:0]           write_count;
  logic [7:0]           write_lo;
  logic [7:0]           write_hi;
  logic [CW-1:0]        pop_eff;
  logic                 pop_over;

  // An odd FIP on a 16-bit bus fetches only the upper lane so the next fetch is aligned.
  always_comb begin
    fetch_size = 2'd1;
    be_next    = '1;
    if (BUS_BYTES == 2) begin
      if (fip[0]) be_next[0] = 1'b0;
      else        fetch_size = 2'd2;
    end
    addr_next = {CS, 4'h0} + {4'h0, fip};
    if (BUS_BYTES == 2) addr_next[0] = 1'b0;
    room_ok = (DEPTH - int'(Q_COUNT)) >= int'(fetch_size);
  end

  always_comb begin
    write_en    = (state == REQ) && MEM_ACK && !IP_LOAD;
    write_lo    = MEM_BE[0] ? MEM_RDATA[7:0] : MEM_RDATA[8*BUS_BYTES-1 -: 8];
    write_hi    = MEM_RDATA[8*BUS_BYTES-1 -: 8];
    write_count = (BUS_BYTES == 2 && MEM_BE == '1) ? 2'd2 : 2'd1;
    if (!write_en) write_count = 2'd0;
    if (int'(POP) > int'(Q_COUNT)) begin
      pop_over = 1'b1;
      pop_eff  = Q_COUNT;
    end else begin
      pop_over = 1'b0;
      pop_eff  = CW'(POP);
    end
  end

  // A request, once issued, is never abandoned on the bus; a flush only marks it for discard.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      MEM_REQ  <= 1'b0;
      MEM_ADDR <= '0;
      MEM_BE   <= '0;
      fip      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!IP_LOAD && !EU_REQ && room_ok) begin
            state    <= REQ;
            MEM_REQ  <= 1'b1;
            MEM_ADDR <= addr_next;
            MEM_BE   <= be_next;
          end
        end
        REQ: begin
          if (MEM_ACK) begin
            state   <= IDLE;
            MEM_REQ <= 1'b0;
            fip     <= fip + 16'(fetch_size);
          end else if (IP_LOAD) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (MEM_ACK) begin
            state   <= IDLE;
            MEM_REQ <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          MEM_REQ <= 1'b0;
        end
      endcase
      if (IP_LOAD) fip <= IP_NEW;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      Q_COUNT  <= '0;
      HEAD_IP  <= '0;
      UNDERRUN <= 1'b0;
      for (int i = 0; i < DEPTH; i++) store[i] <= 8'h00;
    end else if (IP_LOAD) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      Q_COUNT  <= '0;
      HEAD_IP  <= IP_NEW;
      UNDERRUN <= 1'b0;
    end else begin
      if (write_en) begin
        store[wr_ptr] <= write_lo;
        if (write_count == 2'd2) store[wr_ptr + PW'(1)] <= write_hi;
      end
      wr_ptr   <= wr_ptr + PW'(write_count);
      rd_ptr   <= rd_ptr + PW'(pop_eff);
      Q_COUNT  <= Q_COUNT + CW'(write_count) - pop_eff;
      HEAD_IP  <= HEAD_IP + 16'(pop_eff);
      UNDERRUN <= pop_over;
    end
  end

  // Bytes beyond the valid count read as zero so stale entries never leak to the EU.
  always_comb begin
    Q_OUT = '0;
    for (int i = 0; i < OUT_BYTES; i++) begin
      if (i < int'(Q_COUNT)) Q_OUT[8*i +: 8] = store[rd_ptr + PW'(i)];
    end
  end

endmodule

// File: tb/tb_biu_prefetch_queue.sv
// Bench for biu_prefetch_queue: an 8088 instance (DEPTH 4) and an 8086 instance (DEPTH 8)
// compared every cycle against a byte-list model, plus directed literal checks.
module tb_biu_prefetch_queue;
  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cs      [2];
  logic        ip_load [2];
  logic [15:0] ip_new  [2];
  logic        eu_req  [2];
  logic        mem_ack [2];
  logic [2:0]  pop     [2];
  logic [7:0]  rdata0;
  logic [15:0] rdata1;
  logic        mem_req  [2];
  logic [19:0] mem_addr [2];
  logic        be0;
  logic [1:0]  be1;
  logic [31:0] q_out    [2];
  logic [2:0]  cnt0;
  logic [3:0]  cnt1;
  logic [15:0] head_ip  [2];
  logic        underrun [2];

  int checks = 0;
  int errors = 0;

  // Model: queue contents as an ordered byte list, plus the outstanding bus request.
  logic [7:0]  mq    [2][16];
  int          mcnt  [2];
  logic [15:0] mfip  [2];
  logic [15:0] mhip  [2];
  logic        mpend [2];
  logic        mdisc [2];
  logic        munder[2];
  logic [19:0] maddr [2];
  logic [1:0]  mbe   [2];

  always #5 clk = ~clk;

  biu_prefetch_queue #(.BUS_BYTES(1), .DEPTH(4), .OUT_BYTES(4)) dut0 (
    .CLK(clk), .RST(rst_n), .CS(cs[0]), .IP_LOAD(ip_load[0]), .IP_NEW(ip_new[0]),
    .EU_REQ(eu_req[0]), .MEM_REQ(mem_req[0]), .MEM_ADDR(mem_addr[0]), .MEM_BE(be0),
    .MEM_ACK(mem_ack[0]), .MEM_RDATA(rdata0), .POP(pop[0]), .Q_OUT(q_out[0]),
    .Q_COUNT(cnt0), .HEAD_IP(head_ip[0]), .UNDERRUN(underrun[0])
  );

  biu_prefetch_queue #(.BUS_BYTES(2), .DEPTH(8), .OUT_BYTES(4)) dut1 (
    .CLK(clk), .RST(rst_n), .CS(cs[1]), .IP_LOAD(ip_load[1]), .IP_NEW(ip_new[1]),
    .EU_REQ(eu_req[1]), .MEM_REQ(mem_req[1]), .MEM_ADDR(mem_addr[1]), .MEM_BE(be1),
    .MEM_ACK(mem_ack[1]), .MEM_RDATA(rdata1), .POP(pop[1]), .Q_OUT(q_out[1]),
    .Q_COUNT(cnt1), .HEAD_IP(head_ip[1]), .UNDERRUN(underrun[1])
  );

  function automatic int bus_bytes(input int k);
    return k + 1;
  endfunction

  function automatic int depth_of(input int k);
    return 4 * (k + 1);
  endfunction

  function automatic logic [31:0] act_be(input int k);
    return (k == 0) ? {31'd0, be0} : {30'd0, be1};
  endfunction

  function automatic logic [31:0] act_cnt(input int k);
    return (k == 0) ? {29'd0, cnt0} : {28'd0, cnt1};
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int k);
    logic [7:0]  nb [2];
    logic [15:0] d;
    int n, eff, sz, phys;
    n = 0;
    d = (k == 0) ? {8'h00, rdata0} : rdata1;
    if (mpend[k]) begin
      if (mem_ack[k]) begin
        if (!mdisc[k] && !ip_load[k]) begin
          for (int l = 0; l < bus_bytes(k); l++) begin
            if (mbe[k][l]) begin
              nb[n] = d[8*l +: 8];
              n++;
            end
          end
        end
        mpend[k] = 1'b0;
        mdisc[k] = 1'b0;
      end else if (ip_load[k]) begin
        mdisc[k] = 1'b1;
      end
    end else if (!ip_load[k] && !eu_req[k]) begin
      sz = (bus_bytes(k) == 2 && !mfip[k][0]) ? 2 : 1;
      if (depth_of(k) - mcnt[k] >= sz) begin
        phys = (int'(cs[k]) * 16 + int'(mfip[k])) % 1048576;
        if (bus_bytes(k) == 2) phys = (phys / 2) * 2;
        mpend[k] = 1'b1;
        maddr[k] = 20'(phys);
        mbe[k]   = (bus_bytes(k) == 1) ? 2'b01 : (mfip[k][0] ? 2'b10 : 2'b11);
      end
    end
    if (ip_load[k]) begin
      mcnt[k]   = 0;
      mfip[k]   = ip_new[k];
      mhip[k]   = ip_new[k];
      munder[k] = 1'b0;
    end else begin
      eff       = (int'(pop[k]) > mcnt[k]) ? mcnt[k] : int'(pop[k]);
      munder[k] = int'(pop[k]) > mcnt[k];
      for (int i = 0; i < mcnt[k] - eff; i++) mq[k][i] = mq[k][i + eff];
      mcnt[k] = mcnt[k] - eff;
      mhip[k] = 16'((int'(mhip[k]) + eff) % 65536);
      for (int i = 0; i < n; i++) begin
        mq[k][mcnt[k]] = nb[i];
        mcnt[k]++;
      end
      mfip[k] = 16'((int'(mfip[k]) + n) % 65536);
    end
  endtask

  task automatic compare_model(input int k);
    logic [31:0] exp_q;
    exp_q = '0;
    for (int i = 0; i < 4; i++) if (i < mcnt[k]) exp_q[8*i +: 8] = mq[k][i];
    check_output($sformatf("mem_req%0d", k), 32'(mem_req[k]), 32'(mpend[k]));
    if (mpend[k]) begin
      check_output($sformatf("mem_addr%0d", k), 32'(mem_addr[k]), 32'(maddr[k]));
      check_output($sformatf("mem_be%0d", k), act_be(k), 32'(mbe[k]));
    end
    check_output($sformatf("q_count%0d", k), act_cnt(k), 32'(mcnt[k]));
    check_output($sformatf("q_out%0d", k), q_out[k], exp_q);
    check_output($sformatf("head_ip%0d", k), 32'(head_ip[k]), 32'(mhip[k]));
    check_output($sformatf("underrun%0d", k), 32'(underrun[k]), 32'(munder[k]));
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int k = 0; k < 2; k++) begin
          mcnt[k] = 0; mfip[k] = '0; mhip[k] = '0; mpend[k] = 1'b0;
          mdisc[k] = 1'b0; munder[k] = 1'b0; maddr[k] = '0; mbe[k] = '0;
        end
      end else begin
        for (int k = 0; k < 2; k++) model_step(k);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) compare_model(k);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected bench to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input int k, input logic [15:0] csv, input logic [15:0] ip);
    cs[k]      = csv;
    ip_new[k]  = ip;
    ip_load[k] = 1'b1;
    tick();
    ip_load[k] = 1'b0;
  endtask

  task automatic wait_req(input int k);
    int t;
    t = 0;
    while (!mem_req[k] && t < 20) begin
      tick();
      t++;
    end
    check_output($sformatf("req_wait%0d", k), 32'(mem_req[k]), 32'd1);
  endtask

  task automatic serve_fetch(input int k, input logic [15:0] data, input logic [2:0] popv,
                             output logic [19:0] addr, output logic [1:0] be);
    wait_req(k);
    addr = mem_addr[k];
    be   = 2'(act_be(k));
    if (k == 0) rdata0 = data[7:0];
    else        rdata1 = data;
    mem_ack[k] = 1'b1;
    pop[k]     = popv;
    tick();
    mem_ack[k] = 1'b0;
    pop[k]     = 3'd0;
  endtask

  initial begin
    logic [19:0] a;
    logic [1:0]  b;
    for (int k = 0; k < 2; k++) begin
      cs[k] = '0; ip_load[k] = 1'b0; ip_new[k] = '0; eu_req[k] = 1'b1;
      mem_ack[k] = 1'b0; pop[k] = '0;
    end
    rdata0 = '0;
    rdata1 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    check_output("rst_req", 32'(mem_req[0]), 32'd0);
    check_output("rst_addr", 32'(mem_addr[0]), 32'd0);
    check_output("rst_be", act_be(1), 32'd0);
    check_output("rst_count", act_cnt(0), 32'd0);
    check_output("rst_qout", q_out[1], 32'd0);
    check_output("rst_head", 32'(head_ip[1]), 32'd0);
    check_output("rst_underrun", 32'(underrun[0]), 32'd0);

    // 8088: four single-byte fetches fill the queue near the top of the segment
    apply_stimulus(0, 16'hF000, 16'hFFF0);
    eu_req[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      serve_fetch(0, 16'(8'h11 * (i + 1)), 3'd0, a, b);
      check_output($sformatf("t1_addr%0d", i), 32'(a), 32'(20'hFFFF0 + i));
    end
    repeat (3) tick();
    check_output("t1_req_idle", 32'(mem_req[0]), 32'd0);
    check_output("t1_count", act_cnt(0), 32'd4);
    check_output("t1_qout", q_out[0], 32'h44332211);
    check_output("t1_head", 32'(head_ip[0]), 32'h0000FFF0);

    // FIP wraps inside the segment; physical address wraps at 1 MB
    apply_stimulus(0, 16'hFFFF, 16'hFFFF);
    serve_fetch(0, 16'h00AA, 3'd0, a, b);
    check_output("t2_addr0", 32'(a), 32'h0FFEF);
    serve_fetch(0, 16'h00BB, 3'd0, a, b);
    eu_req[0] = 1'b1;
    check_output("t2_addr1", 32'(a), 32'hFFFF0);
    pop[0] = 3'd1;
    tick();
    pop[0] = 3'd0;
    check_output("t2_head", 32'(head_ip[0]), 32'h0);
    check_output("t2_count", act_cnt(0), 32'd1);
    check_output("t2_qout", q_out[0], 32'h000000BB);

    // Pop and write in the same cycle, then an over-pop
    apply_stimulus(0, 16'h0000, 16'h1000);
    eu_req[0] = 1'b0;
    for (int i = 0; i < 3; i++) serve_fetch(0, 16'(i + 1), 3'd0, a, b);
    check_output("t5_count3", act_cnt(0), 32'd3);
    serve_fetch(0, 16'h0004, 3'd2, a, b);
    eu_req[0] = 1'b1;
    check_output("t5_count2", act_cnt(0), 32'd2);
    check_output("t5_qout", q_out[0], 32'h00000403);
    check_output("t5_head", 32'(head_ip[0]), 32'h1002);
    pop[0] = 3'd4;
    tick();
    pop[0] = 3'd0;
    check_output("t5_count0", act_cnt(0), 32'd0);
    check_output("t5_under1", 32'(underrun[0]), 32'd1);
    tick();
    check_output("t5_under0", 32'(underrun[0]), 32'd0);
    check_output("t5_head2", 32'(head_ip[0]), 32'h1004);

    // 8086: odd start fetches one byte on lane 1, then aligned words
    apply_stimulus(1, 16'h0000, 16'h0101);
    eu_req[1] = 1'b0;
    serve_fetch(1, 16'hAB00, 3'd0, a, b);
    check_output("t3_addr0", 32'(a), 32'h00100);
    check_output("t3_be0", 32'(b), 32'h2);
    check_output("t3_count1", act_cnt(1), 32'd1);
    serve_fetch(1, 16'hDCCD, 3'd0, a, b);
    eu_req[1] = 1'b1;
    check_output("t3_addr1", 32'(a), 32'h00102);
    check_output("t3_be1", 32'(b), 32'h3);
    check_output("t3_count3", act_cnt(1), 32'd3);
    check_output("t3_qout", q_out[1], 32'h00DCCDAB);

    // Flush during a slow request: request held, data dropped, refetch from new IP
    apply_stimulus(1, 16'h1234, 16'h0100);
    eu_req[1] = 1'b0;
    wait_req(1);
    check_output("t4_addr_first", 32'(mem_addr[1]), 32'h12440);
    tick();
    ip_new[1]  = 16'h0200;
    ip_load[1] = 1'b1;
    tick();
    ip_load[1] = 1'b0;
    tick();
    check_output("t4_req_held", 32'(mem_req[1]), 32'd1);
    check_output("t4_addr_held", 32'(mem_addr[1]), 32'h12440);
    rdata1     = 16'h5566;
    mem_ack[1] = 1'b1;
    tick();
    mem_ack[1] = 1'b0;
    check_output("t4_count_drop", act_cnt(1), 32'd0);
    check_output("t4_req_low", 32'(mem_req[1]), 32'd0);
    serve_fetch(1, 16'h8877, 3'd0, a, b);
    eu_req[1] = 1'b1;
    check_output("t4_addr_new", 32'(a), 32'h12540);
    check_output("t4_qout", q_out[1], 32'h00008877);
    check_output("t4_head", 32'(head_ip[1]), 32'h0200);

    // EU ownership holds off fetches; reset mid-request clears outputs at once
    apply_stimulus(0, 16'h0000, 16'h2000);
    repeat (3) tick();
    check_output("t6_eu_hold", 32'(mem_req[0]), 32'd0);
    check_output("t6_eu_count", act_cnt(0), 32'd0);
    eu_req[0] = 1'b0;
    tick();
    check_output("t6_req_rise", 32'(mem_req[0]), 32'd1);
    check_output("t6_req_addr", 32'(mem_addr[0]), 32'h02000);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("t6_rst_req", 32'(mem_req[0]), 32'd0);
    check_output("t6_rst_addr", 32'(mem_addr[0]), 32'd0);
    check_output("t6_rst_head", 32'(head_ip[0]), 32'd0);
    check_output("t6_rst_qout1", q_out[1], 32'd0);
    check_output("t6_rst_count1", act_cnt(1), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/biu_prefetch_queue.md
# biu_prefetch_queue

Parametrised bus-interface prefetch unit for the 8088/8086 interface bank. It forms 20-bit physical fetch addresses from CS and an internal fetch pointer, and runs a request/acknowledge fetch engine on the external bus port. It supports 8-bit (8088) or 16-bit (8086) bus width, and a byte queue of configurable depth with flush on IP reload. It also presents a multi-byte window to the execution unit. It sits between the segment register file and the memory/bus control logic, and replaces the fixed 4-byte queue.

## Interface
- BUS_BYTES, 1, bytes per bus transfer: 1 (8088) or 2 (8086).
- DEPTH, 4, queue capacity in bytes; power of two, ≥ 2*BUS_BYTES.
- OUT_BYTES, 4, bytes presented on Q_OUT; ≤ DEPTH.

Ports:
- CLK  in  1  clock, all state changes on rising edge.
- RST  in  1  asynchronous, active-low reset.
- CS  in  16  code segment.
- IP_LOAD  in  1  flush queue and load fetch/head IP from IP_NEW.
- IP_NEW  in  16  new instruction pointer.
- EU_REQ  in  1  execution unit owns the bus; no new prefetch may start.
- MEM_REQ  out  1  fetch request, held until MEM_ACK.
- MEM_ADDR  out  20  physical fetch address; bit 0 forced 0 when BUS_BYTES=2.
- MEM_BE  out  BUS_BYTES  byte-lane enables.
- MEM_ACK  in  1  data valid on MEM_RDATA, request complete.
- MEM_RDATA  in  8*BUS_BYTES  fetched data; lane i = byte at MEM_ADDR+i.
- POP  in  $clog2(OUT_BYTES+1)  bytes consumed this cycle.
- Q_OUT  out  8*OUT_BYTES  head window; byte 0 in [7:0].
- Q_COUNT  out  $clog2(DEPTH+1)  bytes held.
- HEAD_IP  out  16  IP of the byte at Q_OUT[7:0].
- UNDERRUN  out  1  one-cycle pulse, POP exceeded Q_COUNT.

## Operation
- The queue is a circular buffer with read pointer, write pointer and count. The fetch pointer FIP is 16 bits.
- Physical address = ({CS,4'h0} + {4'h0,FIP}) mod 2^20.
- FIP and HEAD_IP increment modulo 2^16 (0xFFFF → 0x0000 within the same CS).
- Fetch size:
  - BUS_BYTES=1: always 1 byte, MEM_BE=1.
  - BUS_BYTES=2, FIP even: 2 bytes, MEM_BE=2'b11.
  - BUS_BYTES=2, FIP odd: 1 byte from lane 1, MEM_BE=2'b10; FIP+=1, so the next fetch is aligned.
- FSM states: IDLE, REQ, DRAIN.
  - IDLE → REQ when !IP_LOAD && !EU_REQ && (DEPTH − Q_COUNT) ≥ fetch size. At that edge MEM_REQ/MEM_ADDR/MEM_BE register.
  - REQ: MEM_REQ, MEM_ADDR and MEM_BE are held stable.
    - On MEM_ACK: the enabled lanes are written in order, FIP advances, state → IDLE, MEM_REQ=0.
    - If IP_LOAD occurs while in REQ without MEM_ACK: → DRAIN.
  - DRAIN: the request is held unchanged until MEM_ACK; data is discarded; then → IDLE. There is no abort on the bus.
  - IP_LOAD with MEM_ACK in the same cycle in REQ: data is discarded, → IDLE.
- Flush (IP_LOAD), in any state: count=0, pointers reset, FIP=HEAD_IP=IP_NEW, UNDERRUN=0. A flush takes priority over POP and ACK writes in that cycle.
- Pop: effective pop = min(POP, Q_COUNT). Read pointer and HEAD_IP advance by the effective pop. UNDERRUN=1 next cycle if POP > Q_COUNT.
- Same-cycle pop and ACK write: Q_COUNT_next = Q_COUNT + written − popped. Space was reserved at request start, so the queue cannot overflow.
- Q_OUT byte i = stored byte at rd+i for i < Q_COUNT, else 8'h00.

## Timing
- Reset values: MEM_REQ=0, MEM_ADDR=0, MEM_BE=0, Q_COUNT=0, Q_OUT=0, HEAD_IP=0, UNDERRUN=0, FIP=0, state IDLE. Reset mid-request drops MEM_REQ immediately.
- Q_OUT, Q_COUNT and HEAD_IP are registered state; Q_OUT is a mux of registers with no input-to-output path.
- Flush at edge N → MEM_REQ=1 with the new address at edge N+1 at the earliest.
- MEM_ACK sampled at edge M → data is visible on Q_OUT after edge M, and MEM_REQ=0 after edge M.
- Back-to-back fetches: the next MEM_REQ rises at M+1 (one idle cycle per transfer). Peak throughput is BUS_BYTES bytes per 2 cycles with single-cycle ACK.
- EU_REQ only gates IDLE→REQ; an in-flight request completes normally.

## Test plan
- DEPTH=4, BUS_BYTES=1, CS=F000, IP_LOAD IP_NEW=FFF0, ACK the cycle after each REQ with data 11,22,33,44 → MEM_ADDR FFFF0..FFFF3; then MEM_REQ stays 0; Q_COUNT=4; Q_OUT=44332211; HEAD_IP=FFF0.
- CS=FFFF, IP_NEW=FFFF → first MEM_ADDR 0FFEF, second FFFF0 (FIP wrapped to 0000). POP 1 → HEAD_IP=0000.
- BUS_BYTES=2, DEPTH=8, CS=0000, IP_NEW=0101 → MEM_ADDR 00100 with MEM_BE=10 (one byte), then 00102 with MEM_BE=11; Q_COUNT 1 then 3.
- ACK delayed 3 cycles, IP_LOAD IP_NEW=0200 in the 2nd wait cycle → MEM_ADDR held until ACK; data discarded; Q_COUNT=0; next MEM_ADDR = CS*16+0200.
- Q_COUNT=3, POP=2 with ACK of 1 byte in the same cycle → Q_COUNT=2. Then POP=4 → Q_COUNT=0 and UNDERRUN pulses once.
- EU_REQ=1 holds fetch off with Q_COUNT=0. Release → MEM_REQ at the next edge. Assert RST=0 mid-REQ → all outputs return to reset values asynchronously.
